muldiv_unit: RTL

Iterative RV32M multiply/divide unit that sits beside the execution unit in the CPU datapath. It consumes the two register-file read operands and funct3 of an `OPCODE_MULDIV` instruction (funct7 = 0000001), computes the result over multiple cycles, and presents it to the register write-back mux. While the unit is busy, the CPU holds the PC and suppresses the register write.

---
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//
// Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 33 cycles. The CPU
// holds the PC and suppresses write-back while busy is high.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst     - synchronous active-high reset
//   start   - begin an operation (sampled only in IDLE)
//   kill    - abort the in-flight operation; in IDLE it blocks start
//   funct3  - RV32M operation select
//   op_a    - rs1 value
//   op_b    - rs2 value
//   busy    - high whenever the unit is not IDLE
//   done    - one-cycle pulse, result valid in that cycle
//   result  - registered result, held until overwritten by the next operation
//
// Handshake: start is accepted at a rising edge only when busy is low and
// kill is low. Once accepted, the operands are latched and further start
// pulses are ignored until busy drops. done pulses for exactly one cycle
// (unless killed) and the unit returns to IDLE on the following edge.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [5:0]        cnt;     // number of completed iterations (0..32)
    logic [2:0]        op;
    logic              neg_a;   // op_a was signed and negative
    logic              neg_b;   // op_b was signed and negative
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    // Multiply: {partial high, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*XLEN-1:0] acc;

    // ---- decode of the incoming operation ----
    logic            is_div_in;
    logic            signed_a_in;
    logic            signed_b_in;
    logic            neg_a_in;
    logic            neg_b_in;
    logic [XLEN-1:0] mag_a_in;
    logic [XLEN-1:0] mag_b_in;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        is_div_in   = funct3[2];
        signed_a_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
        signed_b_in = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                      (funct3 == 3'b110);
        neg_a_in    = signed_a_in && op_a[XLEN-1];
        neg_b_in    = signed_b_in && op_b[XLEN-1];
        mag_a_in    = neg_a_in ? -op_a : op_a;
        mag_b_in    = neg_b_in ? -op_b : op_b;
        div_zero    = is_div_in && (op_b == '0);
        div_ovf     = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (op_b == {XLEN{1'b1}});
        // funct3[1] selects remainder vs quotient for the divide group.
        if (div_zero)
            fast_result = funct3[1] ? op_a : {XLEN{1'b1}};
        else
            fast_result = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // ---- one iteration step ----
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        // Shift-add: add multiplicand to the high half when the current
        // multiplier LSB is set, then shift the whole accumulator right.
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        // Restoring division: shift the next dividend bit into the remainder,
        // subtract the divisor when it fits. The 33-bit trial cannot overflow.
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = div_shift >= {1'b0, mag_b};
        div_diff  = div_shift - {1'b0, mag_b};
        div_next  = {div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0],
                     acc[XLEN-2:0], div_ge};
    end

    // ---- signed fixup on completion ----
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   final_result;

    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quo  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (op[2])
            final_result = op[1] ? rem : quo;
        else if (op[1:0] == 2'b00)
            final_result = prod[XLEN-1:0];
        else
            final_result = prod[2*XLEN-1:XLEN];
    end

    // ---- state machine ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            result <= '0;
            op     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !kill) begin
                        op    <= funct3;
                        neg_a <= neg_a_in;
                        neg_b <= neg_b_in;
                        mag_a <= mag_a_in;
                        mag_b <= mag_b_in;
                        cnt   <= '0;
                        if (div_zero || div_ovf) begin
                            result <= fast_result;
                            state  <= S_DONE;
                        end else begin
                            // Low half holds the multiplier (mul) or dividend (div).
                            acc   <= {{XLEN{1'b0}}, is_div_in ? mag_a_in : mag_b_in};
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        state <= S_IDLE;
                    end else if (cnt == 6'd32) begin
                        result <= final_result;
                        state  <= S_DONE;
                    end else begin
                        acc <= op[2] ? div_next : mul_next;
                        cnt <= cnt + 6'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
